// File: rtl/t20_match_sequencer_pkg.sv
// T20 match sequencer shared types.
// States, outcome codes, winner encodings.
package t20_match_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INN1,
    ST_BREAK,
    ST_INN2,
    ST_DONE
  } state_e;

  localparam logic [2:0] OC_DOT   = 3'd0;
  localparam logic [2:0] OC_ONE   = 3'd1;
  localparam logic [2:0] OC_TWO   = 3'd2;
  localparam logic [2:0] OC_THREE = 3'd3;
  localparam logic [2:0] OC_FOUR  = 3'd4;
  localparam logic [2:0] OC_SIX   = 3'd5;
  localparam logic [2:0] OC_WKT   = 3'd6;
  localparam logic [2:0] OC_ONE_B = 3'd7;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_A    = 2'd1;
  localparam logic [1:0] WIN_B    = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  function automatic logic [2:0] outcome_runs(input logic [2:0] c);
    logic [2:0] r;
    r = 3'd0;
    case (c)
      OC_ONE:   r = 3'd1;
      OC_TWO:   r = 3'd2;
      OC_THREE: r = 3'd3;
      OC_FOUR:  r = 3'd4;
      OC_SIX:   r = 3'd6;
      OC_ONE_B: r = 3'd1;
      default:  r = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/t20_match_sequencer_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Free-running; a nonzero seed keeps it out of the all-zero lock state.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_fpga,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign q  = lfsr_q;

  // Shift every cycle, reload seed on reset.
  always_ff @(posedge clk_fpga) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= {lfsr_q[6:0], fb};
  end

endmodule

// File: rtl/t20_match_sequencer.sv
// T20 match sequencer: two innings, one delivery per play press.
// Outcome from LFSR or forced code; decides winner at end of chase.
module t20_match_sequencer
  import t20_match_sequencer_pkg::*;
#(
  parameter int         MAX_OVERS = 20,
  parameter int         MAX_WKTS  = 10,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk_fpga,
  input  logic       rst,
  input  logic       play,
  input  logic       ovr_en,
  input  logic [2:0] ovr_code,
  output logic [8:0] runs,
  output logic [3:0] wickets,
  output logic [4:0] overs,
  output logic [2:0] balls,
  output logic       innings,
  output logic [8:0] target,
  output logic       ball_valid,
  output logic [2:0] last_outcome,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [3:0] WKT_LIM = 4'(MAX_WKTS);
  localparam logic [4:0] OVR_LIM = 5'(MAX_OVERS);

  state_e     state_q, state_d;
  logic       play_q;
  logic [8:0] runs_q, runs_d;
  logic [3:0] wkts_q, wkts_d;
  logic [4:0] overs_q, overs_d;
  logic [2:0] balls_q, balls_d;
  logic       inn_q, inn_d;
  logic [8:0] tgt_q, tgt_d;
  logic       bv_q, bv_d;
  logic [2:0] last_q, last_d;
  logic       go_q, go_d;
  logic [1:0] win_q, win_d;

  logic [7:0] lfsr_w;
  logic       unused_lfsr;
  logic       evt;
  logic [2:0] code;
  logic [9:0] sum;
  logic [8:0] runs_n;
  logic [3:0] wk_n;
  logic [4:0] ov_n;
  logic [2:0] bl_n;
  logic       lim_hit;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_fpga (clk_fpga),
    .rst      (rst),
    .q        (lfsr_w)
  );

  assign unused_lfsr = ^lfsr_w[7:3];

  assign evt  = play & ~play_q;
  assign code = ovr_en ? ovr_code : lfsr_w[2:0];

  // Candidate counters if a delivery is scored this cycle.
  always_comb begin
    sum    = {1'b0, runs_q} + {7'd0, outcome_runs(code)};
    runs_n = sum[9] ? 9'd511 : sum[8:0];
    wk_n   = wkts_q;
    if (code == OC_WKT && wkts_q < WKT_LIM) wk_n = wkts_q + 4'd1;
    ov_n = overs_q;
    bl_n = balls_q + 3'd1;
    if (balls_q == 3'd5) begin
      bl_n = 3'd0;
      ov_n = overs_q + 5'd1;
    end
    lim_hit = (wk_n == WKT_LIM) || (ov_n == OVR_LIM);
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    runs_d  = runs_q;
    wkts_d  = wkts_q;
    overs_d = overs_q;
    balls_d = balls_q;
    inn_d   = inn_q;
    tgt_d   = tgt_q;
    bv_d    = 1'b0;
    last_d  = last_q;
    go_d    = go_q;
    win_d   = win_q;
    unique case (state_q)
      ST_IDLE: begin
        if (evt) state_d = ST_INN1;
      end
      ST_INN1: begin
        if (evt) begin
          runs_d  = runs_n;
          wkts_d  = wk_n;
          overs_d = ov_n;
          balls_d = bl_n;
          bv_d    = 1'b1;
          last_d  = code;
          if (lim_hit) begin
            state_d = ST_BREAK;
            tgt_d   = (runs_n == 9'd511) ? 9'd511 : runs_n + 9'd1;
          end
        end
      end
      ST_BREAK: begin
        if (evt) begin
          state_d = ST_INN2;
          inn_d   = 1'b1;
          runs_d  = '0;
          wkts_d  = '0;
          overs_d = '0;
          balls_d = '0;
        end
      end
      ST_INN2: begin
        if (evt) begin
          runs_d  = runs_n;
          wkts_d  = wk_n;
          overs_d = ov_n;
          balls_d = bl_n;
          bv_d    = 1'b1;
          last_d  = code;
          if (runs_n >= tgt_q) begin
            state_d = ST_DONE;
            go_d    = 1'b1;
            win_d   = WIN_B;
          end else if (lim_hit) begin
            state_d = ST_DONE;
            go_d    = 1'b1;
            win_d   = (runs_n == tgt_q - 9'd1) ? WIN_TIE : WIN_A;
          end
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state_q <= ST_IDLE;
      play_q  <= 1'b0;
      runs_q  <= '0;
      wkts_q  <= '0;
      overs_q <= '0;
      balls_q <= '0;
      inn_q   <= 1'b0;
      tgt_q   <= '0;
      bv_q    <= 1'b0;
      last_q  <= '0;
      go_q    <= 1'b0;
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      play_q  <= play;
      runs_q  <= runs_d;
      wkts_q  <= wkts_d;
      overs_q <= overs_d;
      balls_q <= balls_d;
      inn_q   <= inn_d;
      tgt_q   <= tgt_d;
      bv_q    <= bv_d;
      last_q  <= last_d;
      go_q    <= go_d;
      win_q   <= win_d;
    end
  end

  assign runs         = runs_q;
  assign wickets      = wkts_q;
  assign overs        = overs_q;
  assign balls        = balls_q;
  assign innings      = inn_q;
  assign target       = tgt_q;
  assign ball_valid   = bv_q;
  assign last_outcome = last_q;
  assign game_over    = go_q;
  assign winner       = win_q;

endmodule

// File: tb/tb_t20_match_sequencer.sv
// Directed bench for t20_match_sequencer.
// One-over, one-wicket configuration to reach innings limits quickly.
module tb_t20_match_sequencer;
  import t20_match_sequencer_pkg::*;

  logic       clk_fpga = 1'b0;
  logic       rst = 1'b1;
  logic       play = 1'b0;
  logic       ovr_en = 1'b1;
  logic [2:0] ovr_code = 3'd0;
  logic [8:0] runs;
  logic [3:0] wickets;
  logic [4:0] overs;
  logic [2:0] balls;
  logic       innings;
  logic [8:0] target;
  logic       ball_valid;
  logic [2:0] last_outcome;
  logic       game_over;
  logic [1:0] winner;

  int n_chk = 0;
  int n_err = 0;
  int bvcnt;

  t20_match_sequencer #(
    .MAX_OVERS (1),
    .MAX_WKTS  (1),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk_fpga     (clk_fpga),
    .rst          (rst),
    .play         (play),
    .ovr_en       (ovr_en),
    .ovr_code     (ovr_code),
    .runs         (runs),
    .wickets      (wickets),
    .overs        (overs),
    .balls        (balls),
    .innings      (innings),
    .target       (target),
    .ball_valid   (ball_valid),
    .last_outcome (last_outcome),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_fpga); #1;
    rst  = 1'b1;
    play = 1'b0;
    @(posedge clk_fpga); #1;
    @(posedge clk_fpga); #1;
    rst = 1'b0;
  endtask

  task automatic press(input logic [2:0] c, input logic exp_bv);
    @(posedge clk_fpga); #1;
    ovr_code = c;
    play     = 1'b1;
    @(posedge clk_fpga); #1;
    chk("bv_pulse", int'(ball_valid), int'(exp_bv));
    if (exp_bv) chk("last_code", int'(last_outcome), int'(c));
    play = 1'b0;
    @(posedge clk_fpga); #1;
    chk("bv_clear", int'(ball_valid), 0);
  endtask

  task automatic to_inn2_t7();
    do_reset();
    press(3'd0, 1'b0);
    for (int i = 0; i < 6; i++) press(3'd1, 1'b1);
    press(3'd0, 1'b0);
    chk("t7_state", int'(dut.state_q), int'(ST_INN2));
    chk("t7_target", int'(target), 7);
  endtask

  initial begin
    do_reset();
    repeat (10) @(posedge clk_fpga);
    #1;
    chk("rst_runs", int'(runs), 0);
    chk("rst_wkts", int'(wickets), 0);
    chk("rst_ovbl", int'({overs, balls}), 0);
    chk("rst_misc", int'({innings, target, last_outcome}), 0);
    chk("rst_flags", int'({ball_valid, game_over, winner}), 0);
    chk("rst_state", int'(dut.state_q), int'(ST_IDLE));

    play  = 1'b1;
    bvcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_fpga); #1;
      bvcnt += int'(ball_valid);
    end
    play = 1'b0;
    chk("hold_bv", bvcnt, 0);
    chk("hold_state", int'(dut.state_q), int'(ST_INN1));

    press(3'd5, 1'b1);
    chk("d1_runs", int'(runs), 6);
    press(3'd4, 1'b1);
    chk("d2_runs", int'(runs), 10);
    press(3'd6, 1'b1);
    chk("d3_runs", int'(runs), 10);
    chk("d3_wkts", int'(wickets), 1);
    chk("d3_balls", int'(balls), 3);
    chk("d3_state", int'(dut.state_q), int'(ST_BREAK));
    chk("d3_target", int'(target), 11);

    do_reset();
    press(3'd0, 1'b0);
    for (int i = 0; i < 6; i++) press(3'd1, 1'b1);
    chk("ov_overs", int'(overs), 1);
    chk("ov_balls", int'(balls), 0);
    chk("ov_state", int'(dut.state_q), int'(ST_BREAK));
    chk("ov_target", int'(target), 7);
    press(3'd2, 1'b0);
    chk("i2_innings", int'(innings), 1);
    chk("i2_counts", int'({runs, wickets, overs, balls}), 0);
    chk("i2_target", int'(target), 7);

    press(3'd5, 1'b1);
    chk("ch_runs6", int'(runs), 6);
    press(3'd1, 1'b1);
    chk("ch_runs7", int'(runs), 7);
    chk("ch_over", int'(game_over), 1);
    chk("ch_winner", int'(winner), 2);
    press(3'd4, 1'b0);
    chk("ch_frozen", int'(runs), 7);
    chk("ch_balls", int'(balls), 2);

    to_inn2_t7();
    press(3'd5, 1'b1);
    press(3'd6, 1'b1);
    chk("tie_over", int'(game_over), 1);
    chk("tie_winner", int'(winner), 3);

    to_inn2_t7();
    press(3'd4, 1'b1);
    press(3'd6, 1'b1);
    chk("a_runs", int'(runs), 4);
    chk("a_winner", int'(winner), 1);

    to_inn2_t7();
    for (int i = 0; i < 4; i++) press(3'd1, 1'b1);
    press(3'd0, 1'b1);
    press(3'd3, 1'b1);
    chk("lb_runs", int'(runs), 7);
    chk("lb_overs", int'(overs), 1);
    chk("lb_winner", int'(winner), 2);

    to_inn2_t7();
    press(3'd1, 1'b1);
    @(posedge clk_fpga); #1;
    ovr_code = 3'd5;
    play     = 1'b1;
    rst      = 1'b1;
    @(posedge clk_fpga); #1;
    chk("rr_state", int'(dut.state_q), int'(ST_IDLE));
    chk("rr_bv", int'(ball_valid), 0);
    chk("rr_runs", int'(runs), 0);
    chk("rr_misc", int'({innings, target, game_over, winner}), 0);
    rst  = 1'b0;
    play = 1'b0;
    @(posedge clk_fpga); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/t20_match_sequencer.md
T20_MATCH_SEQUENCER -- requirements
Module: t20_match_sequencer

Interface
REQ-001 Parameter MAX_OVERS, default 20, overs per innings (1..31).
REQ-002 Parameter MAX_WKTS, default 10, wickets ending an innings (1..15).
REQ-003 Parameter LFSR_SEED, default 8'hA5, nonzero LFSR reset value.
REQ-004 clk_fpga  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 play  in  1  debounced button (from debouncer); level, may stay high several cycles.
REQ-007 ovr_en  in  1  when 1, outcome code taken from ovr_code instead of LFSR (test hook).
REQ-008 ovr_code  in  3  forced outcome code.
REQ-009 runs  out  9  current-innings score.
REQ-010 wickets  out  4  current-innings wickets.
REQ-011 overs  out  5  completed overs; balls  out  3  legal balls in current over (0..5).
REQ-012 innings  out  1  0 = team A batting, 1 = team B batting.
REQ-013 target  out  9  innings-1 runs + 1, valid from BREAK onward, else 0.
REQ-014 ball_valid  out  1  one-cycle pulse when a delivery is scored.
REQ-015 last_outcome  out  3  code of most recent delivery.
REQ-016 game_over  out  1; winner  out  2  (0 none, 1 A, 2 B, 3 tie).

Function
REQ-017 Event = rising edge of play (play high, registered play_q low); further high cycles ignored.
REQ-018 States: IDLE, INN1, BREAK, INN2, DONE.
REQ-019 IDLE: event -> INN1, no delivery scored.
REQ-020 INN1/INN2: event scores one delivery; outputs update at edge N+1 after event at cycle N; ball_valid high that cycle only.
REQ-021 Code = ovr_en ? ovr_code : lfsr[2:0], sampled in event cycle.
REQ-022 Code map: 0 dot, 1 one, 2 two, 3 three, 4 four, 5 six, 6 wicket, 7 one; every code is a legal ball.
REQ-023 Ball increment: balls 5 -> 0 with overs+1, else balls+1; never exceeds MAX_OVERS.0.
REQ-024 runs saturates at 511; wickets never exceed MAX_WKTS.
REQ-025 INN1 ends (same edge as delivery update) when wickets==MAX_WKTS or overs==MAX_OVERS -> BREAK; target latched = runs+1.
REQ-026 BREAK: event -> INN2, innings=1, runs/wickets/overs/balls cleared, no delivery scored.
REQ-027 INN2 ends -> DONE on first of: runs>=target (winner 2); else wickets/overs limit with runs==target-1 (winner 3) or runs<target-1 (winner 1).
REQ-028 Chase completion checked before limit: winning run on last ball or with last wicket gives winner 2.
REQ-029 DONE: game_over=1, events ignored, counters frozen until rst.
REQ-030 LFSR 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle in all states, never zero.

Reset
REQ-031 rst high at an edge: state IDLE, all outputs 0, lfsr=LFSR_SEED, play_q=0; rst overrides any simultaneous event, including mid-innings.

Structure
REQ-032 Shared package holds state enum, outcome code constants, winner encodings.
REQ-033 One sub-module: lfsr8 (clk_fpga, rst, seed parameter, 8-bit out).

Verification
REQ-034 rst then idle 10 cycles -> all outputs 0, state IDLE; play held 20 cycles -> single INN1 entry, no ball_valid.
REQ-035 INN1, ovr_en=1, codes 5,4,6 on three events -> runs 10, wickets 1, balls 3, three ball_valid pulses each 1 cycle after its event.
REQ-036 MAX_OVERS=1, six code-1 events -> overs 1, balls 0, BREAK, target 7; event -> INN2 with counters 0.
REQ-037 INN2 target 7, codes 5 then 1 -> runs 7, DONE, winner 2, further events ignored.
REQ-038 INN2 target 7, MAX_WKTS=1, code 5 then 6 -> winner 3; repeat with code 4 then 6 -> winner 1.
REQ-039 rst asserted together with event mid-INN2 -> next cycle IDLE, outputs 0, no ball_valid.
